// File: rtl/CPU_package.sv
// Shared CPU types: datapath width, ALU opcodes and the arith_arbiter FSM encoding.
package CPU_package;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_INC,
    ALU_OP_DEC,
    ALU_OP_MUL,
    ALU_OP_DIV,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR,
    ALU_OP_SHL,
    ALU_OP_SHR
  } enum_alu_opcode_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } enum_arb_state_t;

  // Returned together with ALU_OP_DIV, this flag pair marks a divide by zero.
  localparam logic [1:0] ARB_FLAG_DIV0 = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant; on a tie the requester that did not win last time wins.
module rr_arbiter_2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/arith_arbiter.sv
// Two-requester round-robin sequencer for the shared combinational Arith unit:
// register operands, capture the result one cycle later, return it to the owner.
module arith_arbiter
  import CPU_package::*;
#(
  parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_carry,
  input  enum_alu_opcode_t      req0_opcode,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_carry,
  input  enum_alu_opcode_t      req1_opcode,

  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_out,
  output logic [1:0]            resp_flag,

  output logic [DATA_WIDTH-1:0] alu_in_a,
  output logic [DATA_WIDTH-1:0] alu_in_b,
  output logic                  alu_carry,
  output enum_alu_opcode_t      alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [1:0]            alu_flag,

  output logic                  busy
);

  enum_arb_state_t         state_q, state_d;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    div0_q;
  logic [DATA_WIDTH+1:0]   result_q;

  logic                    grant0, grant1;
  logic                    accept0, accept1, accept;
  logic                    resp_done;

  rr_arbiter_2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign accept0   = req0_valid & req0_ready;
  assign accept1   = req1_valid & req1_ready;
  assign accept    = accept0 | accept1;
  assign resp_done = owner_q ? resp1_ready : resp0_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  if (resp_done) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // FSM: outputs. Ready is also gated by rst_n so it stays low while reset is held.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        req0_ready = grant0 & rst_n;
        req1_ready = grant1 & rst_n;
        busy       = 1'b0;
      end
      ARB_ISSUE: ;
      ARB_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // Request capture onto the Arith inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_carry    <= 1'b0;
      alu_opcode   <= ALU_OP_ADD;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      div0_q       <= 1'b0;
    end else if (accept) begin
      owner_q      <= accept1;
      last_grant_q <= accept1;
      if (accept1) begin
        alu_in_a   <= req1_a;
        alu_in_b   <= req1_b;
        alu_carry  <= req1_carry;
        alu_opcode <= req1_opcode;
        div0_q     <= (req1_opcode == ALU_OP_DIV) && (req1_b == '0);
      end else begin
        alu_in_a   <= req0_a;
        alu_in_b   <= req0_b;
        alu_carry  <= req0_carry;
        alu_opcode <= req0_opcode;
        div0_q     <= (req0_opcode == ALU_OP_DIV) && (req0_b == '0);
      end
    end
  end

  // Result capture at the end of ISSUE; divide by zero overrides whatever Arith produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (state_q == ARB_ISSUE) begin
      result_q <= div0_q ? {ARB_FLAG_DIV0, {DATA_WIDTH{1'b0}}} : {alu_flag, alu_out};
    end
  end

  assign resp_out  = result_q[DATA_WIDTH-1:0];
  assign resp_flag = result_q[DATA_WIDTH+:2];

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter with a small behavioural Arith attached to the alu_* ports.
module tb_arith_arbiter;
  import CPU_package::*;

  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_carry;
  logic [W-1:0]     req0_a, req0_b;
  enum_alu_opcode_t req0_opcode;
  logic             req1_valid, req1_ready, req1_carry;
  logic [W-1:0]     req1_a, req1_b;
  enum_alu_opcode_t req1_opcode;
  logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0]     resp_out;
  logic [1:0]       resp_flag;
  logic [W-1:0]     alu_in_a, alu_in_b, alu_out;
  logic             alu_carry;
  enum_alu_opcode_t alu_opcode;
  logic [1:0]       alu_flag;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arith_arbiter #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_carry  (req0_carry),
    .req0_opcode (req0_opcode),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_carry  (req1_carry),
    .req1_opcode (req1_opcode),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_out    (resp_out),
    .resp_flag   (resp_flag),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_carry   (alu_carry),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag),
    .busy        (busy)
  );

  // Behavioural Arith: flag = {carry_out, zero}. Divide by zero yields junk the DUT must override.
  logic [W:0] tmp;
  always_comb begin
    tmp      = '0;
    alu_out  = '0;
    alu_flag = '0;
    case (alu_opcode)
      ALU_OP_ADD: tmp = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{W{1'b0}}, alu_carry};
      ALU_OP_INC: tmp = {1'b0, alu_in_a} + 9'd1;
      ALU_OP_DEC: tmp = {1'b0, alu_in_a} - 9'd1;
      ALU_OP_DIV: tmp = (alu_in_b == '0) ? 9'h0FF : {1'b0, alu_in_a / alu_in_b};
      default:    tmp = '0;
    endcase
    alu_out  = tmp[W-1:0];
    alu_flag = {tmp[W], tmp[W-1:0] == '0};
    if (alu_opcode == ALU_OP_DIV && alu_in_b == '0) alu_flag = 2'b10;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction from requester `who` with both response readies high.
  task automatic run_op(input int who, input enum_alu_opcode_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_out,
                        input logic [1:0] exp_flag, input string tag);
    logic rdy;
    rdy = 1'b0;
    if (who == 0) begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_carry = cin; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_carry = cin; req1_valid = 1'b1;
    end
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      rdy = (who == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      @(negedge clk);
    end
    check({tag, "_ready"}, rdy, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_resp_own"}, (who == 0) ? resp0_valid : resp1_valid, 1);
    check({tag, "_resp_other"}, (who == 0) ? resp1_valid : resp0_valid, 0);
    check({tag, "_out"}, resp_out, exp_out);
    check({tag, "_flag"}, resp_flag, exp_flag);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
  endtask

  int seen;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_carry = 1'b0; req0_opcode = ALU_OP_INC;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_carry = 1'b0; req1_opcode = ALU_OP_DEC;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // Reset held with both requesters valid
    repeat (2) @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_resp0", resp0_valid, 0);
    check("rst_resp1", resp1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_opcode", alu_opcode, ALU_OP_ADD);
    check("rst_alu_a", alu_in_a, 0);

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, ALU_OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 2'b00, "add");
    check("add_alu_a_held", alu_in_a, 8'h0F);

    // Contention: reset so last_grant=1 and req0 wins the first tie
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_opcode = ALU_OP_INC; req0_a = 8'd5; req0_b = '0; req0_valid = 1'b1;
    req1_opcode = ALU_OP_DEC; req1_a = 8'd5; req1_b = '0; req1_valid = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("cont%0d_ready0", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont%0d_ready1", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      @(negedge clk);
      check($sformatf("cont%0d_issue_rdy", k), {req0_ready, req1_ready}, 0);
      @(negedge clk);
      check($sformatf("cont%0d_resp0", k), resp0_valid, (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont%0d_resp1", k), resp1_valid, (k % 2 == 1) ? 1 : 0);
      check($sformatf("cont%0d_out", k), resp_out, (k % 2 == 0) ? 6 : 4);
      check($sformatf("cont%0d_resp_rdy", k), {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure on requester 1 while requester 0 keeps asking
    req1_opcode = ALU_OP_ADD; req1_a = 8'd3; req1_b = 8'd4; req1_carry = 1'b1;
    req1_valid = 1'b1;
    resp1_ready = 1'b0;
    #1;
    check("bp_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_opcode = ALU_OP_ADD; req0_a = 8'd1; req0_b = 8'd1; req0_carry = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_resp1", i), resp1_valid, 1);
      check($sformatf("bp%0d_out", i), resp_out, 8'd8);
      check($sformatf("bp%0d_busy", i), busy, 1);
      check($sformatf("bp%0d_ready0", i), req0_ready, 0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clk);
    check("bp_release_busy", busy, 0);
    check("bp_release_resp1", resp1_valid, 0);

    // Divide by zero, then a legal divide
    run_op(0, ALU_OP_DIV, 8'h20, 8'h00, 1'b0, 8'h00, 2'b11, "div0");
    run_op(0, ALU_OP_DIV, 8'h20, 8'h04, 1'b0, 8'h08, 2'b00, "div4");

    // Reset while a response is pending
    req0_opcode = ALU_OP_ADD; req0_a = 8'd2; req0_b = 8'd2; req0_carry = 1'b0;
    req0_valid = 1'b1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("rr_pending", resp0_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rr_async_resp0", resp0_valid, 0);
    check("rr_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp0_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) seen++;
    end
    check("rr_no_resp", seen, 0);
    run_op(1, ALU_OP_ADD, 8'd1, 8'd2, 1'b0, 8'd3, 2'b00, "rr_req1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
